// File: rtl/mmio_ioport_pkg.sv
// mmio_ioport_pkg: register offsets, status bit positions and read-select encoding
// shared by the MMIO I/O port and its testbench.
`default_nettype none

package mmio_ioport_pkg;

  localparam logic [15:0] OFF_LED  = 16'd0;
  localparam logic [15:0] OFF_DATA = 16'd1;
  localparam logic [15:0] OFF_STAT = 16'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_TX_OVF   = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LED  = 2'd1,
    SEL_DATA = 2'd2,
    SEL_STAT = 2'd3
  } reg_sel_e;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_ioport_sync_fifo.sv
// sync_fifo: power-of-two depth FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle. Storage is not reset, only pointers and count.
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_ioport.sv
// +------------------------------------------------------------------------------+
// | mmio_ioport: LED register, UART TX/RX byte queues and status at BASE_ADDR..+2 |
// | Define MMIO_IOPORT_RX_FIFO_EN for an RX_DEPTH RX FIFO, else a 1-byte holder.  |
// | Revision: 1.0                                                                 |
// +------------------------------------------------------------------------------+
`default_nettype none

module mmio_ioport
  import mmio_ioport_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int          LED_W     = 6,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in,
  input  logic [15:0]      address,
  input  logic             load,
  input  logic             rd,
  output logic [15:0]      out,
  output logic [LED_W-1:0] led,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;

  reg_sel_e         sel;
  logic [LED_W-1:0] led_q;
  logic             tx_ovf_q, tx_ovf_d;
  logic             rx_ovf_q, rx_ovf_d;

  always_comb begin
    sel = SEL_NONE;
    if (address == BASE_ADDR + OFF_LED)       sel = SEL_LED;
    else if (address == BASE_ADDR + OFF_DATA) sel = SEL_DATA;
    else if (address == BASE_ADDR + OFF_STAT) sel = SEL_STAT;
  end

  logic wr_led, wr_stat;
  assign wr_led  = load && (sel == SEL_LED);
  assign wr_stat = load && (sel == SEL_STAT);

  // ---------------- TX path ----------------
  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic [TXCW-1:0] tx_count;

  assign tx_push  = load && (sel == SEL_DATA);
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (in[7:0]),
    .data_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // ---------------- RX path ----------------
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head_raw, rx_head;
  logic [31:0] rx_count32;

  assign rx_push = rx_valid;
  assign rx_pop  = rd && (sel == SEL_DATA) && !rx_empty;

`ifdef MMIO_IOPORT_RX_FIFO_EN
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  logic [RXCW-1:0] rx_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_data),
    .data_o  (rx_head_raw),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign rx_count32 = 32'(rx_count);
`else
  logic       rx_hold_full_q;
  logic [7:0] rx_hold_q;

  // A byte arriving while the holder is full survives only if it is popped this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold_full_q <= 1'b0;
    end else if (rx_push) begin
      rx_hold_full_q <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push && (!rx_hold_full_q || rx_pop)) rx_hold_q <= rx_data;
  end

  assign rx_full     = rx_hold_full_q;
  assign rx_empty    = !rx_hold_full_q;
  assign rx_head_raw = rx_hold_q;
  assign rx_count32  = {31'd0, rx_hold_full_q};
`endif

  assign rx_head = rx_empty ? 8'h00 : rx_head_raw;

  // ---------------- LED and sticky flags ----------------
  always_comb begin
    tx_ovf_d = tx_ovf_q && !(wr_stat && in[ST_TX_OVF]);
    rx_ovf_d = rx_ovf_q && !(wr_stat && in[ST_RX_OVF]);
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (wr_led) led_q <= in[LED_W-1:0];
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  assign led = ~led_q;

  // ---------------- Read mux ----------------
  logic [15:0] status;

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[15:8]        = sat8(rx_count32);
  end

  always_comb begin
    out = 16'h0000;
    case (sel)
      SEL_LED:  out = 16'(led_q);
      SEL_DATA: out = {!rx_empty, 7'b0, rx_head};
      SEL_STAT: out = status;
      default:  out = 16'h0000;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{in, tx_count};

endmodule

`default_nettype wire

// File: doc/mmio_ioport.md
MMIO_IOPORT -- requirements
Module: mmio_ioport

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h4000, address of the first of three registers.
REQ-002 SHALL have parameter LED_W, default 6, number of LED bits (1..16).
REQ-003 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries (power of 2, >=2).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Ports: clk  in  1  system clock; rst  in  1  async active-high reset.
REQ-007 Ports: in  in  16  write data; address  in  16  CPU address; load  in  1  write strobe; rd  in  1  read-consume strobe.
REQ-008 Ports: out  out  16  combinational read data; led  out  LED_W  active-low LED drive.
REQ-009 Ports: tx_data  out  8; tx_valid  out  1; tx_ready  in  1 (valid/ready to UART core).
REQ-010 Ports: rx_data  in  8; rx_valid  in  1 (single-cycle byte strobe from UART core).

Function
REQ-011 Map: BASE+0 LED (RW); BASE+1 UART data; BASE+2 status; any other address: out=0, writes ignored.
REQ-012 LED write: load at BASE+0 latches in[LED_W-1:0] at clk edge; led = ~reg; read returns reg zero-extended.
REQ-013 Data write: load at BASE+1 pushes in[7:0] into TX FIFO; if full, byte dropped, sticky tx_ovf set.
REQ-014 tx_valid = TX FIFO non-empty, tx_data = head; entry popped on edge where tx_valid && tx_ready.
REQ-015 Push latency: byte written at edge k visible on tx_valid/tx_data from cycle k+1 (empty FIFO).
REQ-016 Data read: out = {rx_nonempty, 7'b0, rx_head}; rx_head = 0 when empty.
REQ-017 rd && address==BASE+1 && RX non-empty pops one entry at edge; rd on empty has no effect.
REQ-018 rx_valid pushes rx_data into RX FIFO; if full and no same-cycle pop, byte dropped, sticky rx_ovf set.
REQ-019 Simultaneous push and pop on either FIFO: both occur, count unchanged, no overflow even when full.
REQ-020 Status read: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_ovf, bit4 tx_ovf, bits[15:8] RX count (saturating at 255), others 0.
REQ-021 Status write: in[3]=1 clears rx_ovf, in[4]=1 clears tx_ovf; new overflow event in same cycle wins (flag stays set).
REQ-022 FIFO pointers wrap modulo depth; count width clog2(depth)+1 to distinguish full from empty.
REQ-023 load and rd to different registers in one cycle SHALL both take effect.

Reset
REQ-024 rst asserted: LED reg 0 (led all ones), both FIFOs empty, tx_valid 0, rx_ovf/tx_ovf 0, immediately without clk.
REQ-025 Reset mid-transfer discards FIFO contents; a byte with tx_valid high is withdrawn, no handshake completes.
REQ-026 No storage array contents SHALL require reset; only pointers, counts, flags.

Configuration
REQ-027 Macro MMIO_IOPORT_RX_FIFO_EN defined: RX path is RX_DEPTH-entry FIFO as above.
REQ-028 Macro undefined: RX path is single holding register (effective depth 1); RX_DEPTH ignored; status count 0 or 1; all overflow rules apply.

Structure
REQ-029 Shared package mmio_ioport_pkg SHALL hold register offsets (0,1,2) and status bit index constants.
REQ-030 Both FIFOs SHALL be instances of one sub-module sync_fifo (parametrised width/depth, push/pop/full/empty/count).
REQ-031 Address decode and read mux SHALL be combinational; all state in clk/rst processes.

Verification
REQ-032 Reset then read BASE+0 -> out=0, led=6'b111111; write 16'h0015 -> next cycle led=6'b101010.
REQ-033 tx_ready=0, write 17 bytes 0x41.. to BASE+1 -> status bit0=1, bit4=1; 17th byte absent; tx_ready=1 -> 16 bytes 0x41..0x50 in order.
REQ-034 Inject rx_data 0x55 with rx_valid -> read BASE+1 gives 16'h8055, status[15:8]=1; rd pops -> 16'h0000.
REQ-035 Fill RX to 16, inject byte with simultaneous rd pop -> count stays 16, rx_ovf=0; inject without pop -> rx_ovf=1; write status 16'h0008 -> cleared.
REQ-036 Assert rst while TX holds 3 bytes and tx_valid=1 -> tx_valid drops same cycle, status reads 16'h0006 after release.
REQ-037 Build without MMIO_IOPORT_RX_FIFO_EN, inject 0x11 then 0x22 -> read 16'h8011, rx_ovf=1.
